// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle datapath.
// Sequences one instruction at a time and drives the write enables of the
// PC, IR, A/B, ALUOut and MDR holding registers, the register-file write,
// the memory request/strobe and the datapath mux selects.
//
// Optional feature: define MC_CTRL_BNE_EN to decode opcode 010001 (bne).
// Without it, 010001 is treated as an illegal opcode.
//
// Ports:
//   CLK        - system clock, rising edge
//   RST        - asynchronous active-high reset
//   Instr_Op   - opcode, IR[31:26]
//   Zero       - ALU zero flag, used in BRANCH
//   Mem_Ready  - memory has completed the current access
//   Mem_Req    - memory access request
//   Mem_WE     - memory write strobe
//   PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE - register enables
//   PC_Sel     - 0 = PC+4, 1 = branch target
//   ALU_B_Sel  - 0 = B, 1 = sign-extended immediate
//   RF_WD_Sel  - 0 = ALUOut, 1 = MDR
//   Illegal    - one-cycle pulse on an undefined opcode
//   State      - current state code (debug)
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Instr_Op,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       Mem_Req,
    output logic       Mem_WE,
    output logic       PC_WE,
    output logic       IR_WE,
    output logic       AB_WE,
    output logic       ALUOut_WE,
    output logic       MDR_WE,
    output logic       RF_WE,
    output logic       PC_Sel,
    output logic       ALU_B_Sel,
    output logic       RF_WD_Sel,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [5:0] OpRType = 6'b100000;
    localparam logic [5:0] OpAluI  = 6'b111000;
    localparam logic [5:0] OpLw    = 6'b000011;
    localparam logic [5:0] OpSw    = 6'b000111;
    localparam logic [5:0] OpB     = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b010000;
    localparam logic [5:0] OpBne   = 6'b010001;

    typedef enum logic [3:0] {
        StInit    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StExecR   = 4'd3,
        StExecI   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWr   = 4'd7,
        StWbAlu   = 4'd8,
        StWbMem   = 4'd9,
        StBranch  = 4'd10,
        StIllegal = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   bne_op;

`ifdef MC_CTRL_BNE_EN
    assign bne_op = (Instr_Op == OpBne);
`else
    assign bne_op = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = StInit;
        Mem_Req   = 1'b0;
        Mem_WE    = 1'b0;
        PC_WE     = 1'b0;
        IR_WE     = 1'b0;
        AB_WE     = 1'b0;
        ALUOut_WE = 1'b0;
        MDR_WE    = 1'b0;
        RF_WE     = 1'b0;
        PC_Sel    = 1'b0;
        ALU_B_Sel = 1'b0;
        RF_WD_Sel = 1'b0;
        Illegal   = 1'b0;

        case (state_q)
            StInit: state_d = StFetch;
            StFetch: begin
                Mem_Req = 1'b1;
                // IR and PC load only on the cycle the fetch completes.
                IR_WE   = Mem_Ready;
                PC_WE   = Mem_Ready;
                state_d = Mem_Ready ? StDecode : StFetch;
            end
            StDecode: begin
                AB_WE = 1'b1;
                if (Instr_Op == OpRType) begin
                    state_d = StExecR;
                end else if (Instr_Op == OpAluI) begin
                    state_d = StExecI;
                end else if (Instr_Op == OpLw || Instr_Op == OpSw) begin
                    state_d = StMemAddr;
                end else if (Instr_Op == OpB || Instr_Op == OpBeq || bne_op) begin
                    state_d = StBranch;
                end else begin
                    state_d = StIllegal;
                end
            end
            StExecR: begin
                ALUOut_WE = 1'b1;
                state_d   = StWbAlu;
            end
            StExecI: begin
                ALUOut_WE = 1'b1;
                ALU_B_Sel = 1'b1;
                state_d   = StWbAlu;
            end
            StMemAddr: begin
                ALUOut_WE = 1'b1;
                ALU_B_Sel = 1'b1;
                state_d   = (Instr_Op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                Mem_Req = 1'b1;
                MDR_WE  = Mem_Ready;
                state_d = Mem_Ready ? StWbMem : StMemRd;
            end
            StMemWr: begin
                Mem_Req = 1'b1;
                Mem_WE  = 1'b1;
                state_d = Mem_Ready ? StFetch : StMemWr;
            end
            StWbAlu: begin
                RF_WE   = 1'b1;
                state_d = StFetch;
            end
            StWbMem: begin
                RF_WE     = 1'b1;
                RF_WD_Sel = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                PC_Sel  = 1'b1;
                PC_WE   = (Instr_Op == OpB) | ((Instr_Op == OpBeq) & Zero) | (bne_op & ~Zero);
                state_d = StFetch;
            end
            StIllegal: begin
                Illegal = 1'b1;
                state_d = StFetch;
            end
            // Unused encodings recover through INIT with all outputs low.
            default: state_d = StInit;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Output vector bit order:
//   [11] Mem_Req [10] Mem_WE [9] PC_WE [8] IR_WE [7] AB_WE [6] ALUOut_WE
//   [5] MDR_WE [4] RF_WE [3] PC_Sel [2] ALU_B_Sel [1] RF_WD_Sel [0] Illegal
module tb_multicycle_ctrl;

    logic       CLK;
    logic       RST;
    logic [5:0] Instr_Op;
    logic       Zero;
    logic       Mem_Ready;
    logic       Mem_Req, Mem_WE, PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE;
    logic       PC_Sel, ALU_B_Sel, RF_WD_Sel, Illegal;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .Instr_Op  (Instr_Op),
        .Zero      (Zero),
        .Mem_Ready (Mem_Ready),
        .Mem_Req   (Mem_Req),
        .Mem_WE    (Mem_WE),
        .PC_WE     (PC_WE),
        .IR_WE     (IR_WE),
        .AB_WE     (AB_WE),
        .ALUOut_WE (ALUOut_WE),
        .MDR_WE    (MDR_WE),
        .RF_WE     (RF_WE),
        .PC_Sel    (PC_Sel),
        .ALU_B_Sel (ALU_B_Sel),
        .RF_WD_Sel (RF_WD_Sel),
        .Illegal   (Illegal),
        .State     (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] outs();
        return {Mem_Req, Mem_WE, PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE,
                PC_Sel, ALU_B_Sel, RF_WD_Sel, Illegal};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply Mem_Ready, check state and outputs, advance.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [11:0] o);
        Mem_Ready = rdy;
        #1;
        check_eq({tag, " state"}, {28'd0, State}, {28'd0, st});
        check_eq({tag, " outs"}, {20'd0, outs()}, {20'd0, o});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        Instr_Op  = 6'b000000;
        Zero      = 1'b0;
        Mem_Ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset state", {28'd0, State}, 32'd0);
        check_eq("reset outs", {20'd0, outs()}, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // R-type
        Instr_Op = 6'b100000;
        cyc("r fetch", 1'b1, 4'd1, 12'hB00);
        cyc("r decode", 1'b1, 4'd2, 12'h080);
        cyc("r exec", 1'b1, 4'd3, 12'h040);
        cyc("r wb", 1'b1, 4'd8, 12'h010);

        // ALU-immediate; Mem_Ready low outside memory states must be ignored
        Instr_Op = 6'b111000;
        cyc("i fetch wait", 1'b0, 4'd1, 12'h800);
        cyc("i fetch", 1'b1, 4'd1, 12'hB00);
        cyc("i decode", 1'b0, 4'd2, 12'h080);
        cyc("i exec", 1'b0, 4'd4, 12'h044);
        cyc("i wb", 1'b0, 4'd8, 12'h010);

        // lw with two wait cycles in MEM_RD
        Instr_Op = 6'b000011;
        cyc("lw fetch", 1'b1, 4'd1, 12'hB00);
        cyc("lw decode", 1'b1, 4'd2, 12'h080);
        cyc("lw addr", 1'b1, 4'd5, 12'h044);
        cyc("lw rd wait1", 1'b0, 4'd6, 12'h800);
        cyc("lw rd wait2", 1'b0, 4'd6, 12'h800);
        cyc("lw rd", 1'b1, 4'd6, 12'h820);
        cyc("lw wb", 1'b1, 4'd9, 12'h012);

        // sw with one wait cycle
        Instr_Op = 6'b000111;
        cyc("sw fetch", 1'b1, 4'd1, 12'hB00);
        cyc("sw decode", 1'b1, 4'd2, 12'h080);
        cyc("sw addr", 1'b1, 4'd5, 12'h044);
        cyc("sw wr wait", 1'b0, 4'd7, 12'hC00);
        cyc("sw wr", 1'b1, 4'd7, 12'hC00);

        // beq taken / not taken, b with Zero=0
        Instr_Op = 6'b010000;
        Zero     = 1'b1;
        cyc("beq1 fetch", 1'b1, 4'd1, 12'hB00);
        cyc("beq1 decode", 1'b1, 4'd2, 12'h080);
        cyc("beq1 branch", 1'b1, 4'd10, 12'h208);
        Zero = 1'b0;
        cyc("beq0 fetch", 1'b1, 4'd1, 12'hB00);
        cyc("beq0 decode", 1'b1, 4'd2, 12'h080);
        cyc("beq0 branch", 1'b1, 4'd10, 12'h008);
        Instr_Op = 6'b000000;
        cyc("b fetch", 1'b1, 4'd1, 12'hB00);
        cyc("b decode", 1'b1, 4'd2, 12'h080);
        cyc("b branch", 1'b1, 4'd10, 12'h208);

        // 010001
        Instr_Op = 6'b010001;
        cyc("op11 fetch", 1'b1, 4'd1, 12'hB00);
        cyc("op11 decode", 1'b1, 4'd2, 12'h080);
`ifdef MC_CTRL_BNE_EN
        cyc("bne0 branch", 1'b1, 4'd10, 12'h208);
        Zero = 1'b1;
        cyc("bne1 fetch", 1'b1, 4'd1, 12'hB00);
        cyc("bne1 decode", 1'b1, 4'd2, 12'h080);
        cyc("bne1 branch", 1'b1, 4'd10, 12'h008);
        Zero = 1'b0;
`else
        cyc("op11 illegal", 1'b1, 4'd11, 12'h001);
`endif

        // Arbitrary undefined opcode; Illegal must be a single-cycle pulse
        Instr_Op = 6'b111111;
        cyc("ill fetch", 1'b1, 4'd1, 12'hB00);
        cyc("ill decode", 1'b1, 4'd2, 12'h080);
        cyc("ill state", 1'b1, 4'd11, 12'h001);

        // Reset during a MEM_RD wait
        Instr_Op = 6'b000011;
        cyc("rst fetch", 1'b1, 4'd1, 12'hB00);
        cyc("rst decode", 1'b1, 4'd2, 12'h080);
        cyc("rst addr", 1'b1, 4'd5, 12'h044);
        Mem_Ready = 1'b0;
        #1;
        check_eq("rst pre state", {28'd0, State}, 32'd6);
        check_eq("rst pre outs", {20'd0, outs()}, 32'h800);
        RST = 1'b1;
        #1;
        check_eq("rst async state", {28'd0, State}, 32'd0);
        check_eq("rst async outs", {20'd0, outs()}, 32'd0);
        @(posedge CLK);
        #1;
        check_eq("rst held state", {28'd0, State}, 32'd0);
        RST       = 1'b0;
        Mem_Ready = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("rst release state", {28'd0, State}, 32'd1);
        check_eq("rst release outs", {20'd0, outs()}, 32'hB00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore control FSM for the multicycle datapath. It sequences one instruction at a time and drives the write-enable (`WE`) inputs of the datapath's 32-bit holding registers: PC, IR, A/B, ALUOut and MDR. It also drives the register-file write, the memory request and the datapath mux selects. The block sits directly upstream of those registers: every `*_WE` output connects straight to a register's `WE` input.

## Interface
- No parameters. Opcodes are fixed constants.
- `CLK`  in  1  — system clock; all state changes on the rising edge.
- `RST`  in  1  — asynchronous, active-high reset.
- `Instr_Op`  in  6  — opcode, IR[31:26].
- `Zero`  in  1  — ALU zero flag; valid in `BRANCH`.
- `Mem_Ready`  in  1  — memory has completed the current access.
- `Mem_Req`  out  1  — memory access request.
- `Mem_WE`  out  1  — memory write strobe.
- `PC_WE`, `IR_WE`, `AB_WE`, `ALUOut_WE`, `MDR_WE`, `RF_WE`  out  1 each  — register enables.
- `PC_Sel`  out  1  — 0 = PC+4, 1 = branch target.
- `ALU_B_Sel`  out  1  — 0 = B, 1 = sign-extended immediate.
- `RF_WD_Sel`  out  1  — 0 = ALUOut, 1 = MDR.
- `Illegal`  out  1  — one-cycle pulse on an undefined opcode.
- `State`  out  4  — current state code, for debug.

## Operation
Opcodes:
- `100000` R-type
- `111000` ALU-immediate
- `000011` lw
- `000111` sw
- `000000` b (unconditional)
- `010000` beq
- Every other opcode is illegal.

States, with their codes, active outputs and transitions. Any output not listed is 0 in that state.

- `INIT`=0: all outputs 0. Always goes to `FETCH`.
- `FETCH`=1:
  - `Mem_Req`=1.
  - `IR_WE` = `PC_WE` = `Mem_Ready` (Mealy qualifier); `PC_Sel`=0.
  - Stays in `FETCH` while `Mem_Ready`=0; goes to `DECODE` when `Mem_Ready`=1.
- `DECODE`=2: `AB_WE`=1. Next state by opcode:
  - R-type → `EXEC_R`
  - ALU-immediate → `EXEC_I`
  - lw, sw → `MEM_ADDR`
  - b, beq → `BRANCH`
  - otherwise → `ILLEGAL`
- `EXEC_R`=3: `ALUOut_WE`=1, `ALU_B_Sel`=0. Goes to `WB_ALU`.
- `EXEC_I`=4: `ALUOut_WE`=1, `ALU_B_Sel`=1. Goes to `WB_ALU`.
- `MEM_ADDR`=5: `ALUOut_WE`=1, `ALU_B_Sel`=1. Goes to `MEM_RD` for lw, `MEM_WR` for sw.
- `MEM_RD`=6:
  - `Mem_Req`=1; `MDR_WE` = `Mem_Ready`.
  - Stays in `MEM_RD` until `Mem_Ready`=1, then goes to `WB_MEM`.
- `MEM_WR`=7:
  - `Mem_Req`=1, `Mem_WE`=1.
  - Stays in `MEM_WR` until `Mem_Ready`=1, then goes to `FETCH`.
- `WB_ALU`=8: `RF_WE`=1, `RF_WD_Sel`=0. Goes to `FETCH`.
- `WB_MEM`=9: `RF_WE`=1, `RF_WD_Sel`=1. Goes to `FETCH`.
- `BRANCH`=10:
  - `ALU_B_Sel`=0, `PC_Sel`=1.
  - `PC_WE` = (op==b) | (op==beq & `Zero`).
  - Goes to `FETCH`.
- `ILLEGAL`=11: `Illegal`=1; no enables asserted. Goes to `FETCH`.
- Unused codes 12–15 go to `INIT`; all their outputs are 0.

Rules:
- Outputs are decoded from the state register only, except the `Mem_Ready` and `Zero` qualifiers listed above.
- No enable is ever asserted in `INIT` or `ILLEGAL`.

## Timing
- Reset:
  - `RST`=1 forces `State`=`INIT` immediately (asynchronous), so every output reads 0 while reset is held.
  - The first `FETCH` begins on the first rising edge after `RST` deasserts.
- Reset during a memory wait abandons the access: `Mem_Req` drops at once and no enable fires.
- With `Mem_Ready` held high, cycles per instruction are:
  - R-type / ALU-immediate: 4
  - lw: 5
  - sw: 4
  - b / beq: 3
  - illegal: 3
- Each wait cycle (`Mem_Ready`=0) adds one cycle in `FETCH`, `MEM_RD` or `MEM_WR`.
- `Mem_Ready` is sampled only in those three states and ignored elsewhere.
- Register timing: an enable asserted in cycle N loads its register at the edge ending cycle N. `Instr_Op` is therefore stable from `DECODE` onward.

## Configuration
- `MC_CTRL_BNE_EN` defined:
  - Opcode `010001` (bne) is decoded in `DECODE` and goes to `BRANCH`.
  - In `BRANCH` for bne: `PC_WE` = ~`Zero`.
- `MC_CTRL_BNE_EN` undefined: `010001` is illegal (`DECODE` → `ILLEGAL`, `Illegal` pulses).

## Test plan
- Reset:
  - Assert `RST` mid-`MEM_RD` with `Mem_Ready`=0 → `State`=0 and all outputs 0 immediately.
  - Release `RST` → `State` reads 1 one cycle later.
- R-type (`100000`), `Mem_Ready`=1:
  - `State` sequence is 1,2,3,8,1.
  - `IR_WE`/`PC_WE` high only in state 1; `RF_WE`=1 with `RF_WD_Sel`=0 only in state 8.
- lw (`000011`), `Mem_Ready` low for 2 cycles in `MEM_RD`:
  - `State` sequence is 1,2,5,6,6,6,9,1.
  - `MDR_WE` high only on the third cycle in state 6; `RF_WD_Sel`=1 in state 9.
- sw (`000111`): `Mem_WE`=1 only in state 7, and `RF_WE` is never asserted during the instruction.
- beq (`010000`):
  - With `Zero`=1: `PC_WE`=1, `PC_Sel`=1 in state 10.
  - With `Zero`=0: `PC_WE`=0 in state 10.
  - b (`000000`) with `Zero`=0: `PC_WE`=1.
- Opcode `010001`:
  - Macro undefined: `State` 2→11, `Illegal`=1 for exactly one cycle, then `FETCH`.
  - Macro defined with `Zero`=0: `State` 2→10 and `PC_WE`=1.
